// File: rtl/frame_decode_pkg.sv
// ----------------------------------------------------------------------------
// frame_decode_pkg
// Shared ISO/IEC 14443-3 type A definitions used by the frame decoder and the
// CRC_A engine: frame decoder state encoding and CRC_A constants.
// ----------------------------------------------------------------------------
package frame_decode_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    ERROR
  } FrameDecodeState;

  localparam logic [15:0] CRC_A_INIT           = 16'h6363;
  localparam logic [15:0] CRC_A_POLY_REFLECTED = 16'h8408;
  localparam logic [15:0] CRC_A_RESIDUE        = 16'h0000;

endpackage

// File: rtl/frame_decode_crc.sv
// ----------------------------------------------------------------------------
// crc_a_bitwise
// Bit-serial CRC_A (x^16+x^12+x^5+1, reflected, init 0x6363, LSB first).
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset (crc returns to init)
//   init        load CRC_A_INIT (has priority over en)
//   en          fold bit_in into the register this cycle
//   bit_in      serial data bit
//   crc         current CRC register contents
// ----------------------------------------------------------------------------
module crc_a_bitwise
  import frame_decode_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        init,
  input  logic        en,
  input  logic        bit_in,
  output logic [15:0] crc
);

  logic [15:0] crc_q;
  logic [15:0] crc_d;

  // Reflected shift: feedback is register LSB xor incoming bit.
  always_comb begin
    crc_d = {1'b0, crc_q[15:1]};
    if (crc_q[0] ^ bit_in) begin
      crc_d = crc_d ^ CRC_A_POLY_REFLECTED;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc_q <= CRC_A_INIT;
    end else if (init) begin
      crc_q <= CRC_A_INIT;
    end else if (en) begin
      crc_q <= crc_d;
    end
  end

  assign crc = crc_q;

endmodule

// File: rtl/frame_decode.sv
// ----------------------------------------------------------------------------
// frame_decode
// Assembles the ISO/IEC 14443-3 PCD->PICC bit stream (one bit per strobe,
// LSB first, odd parity after every 8 data bits) into bytes.
// Optional feature macro: FRAME_DECODE_CRC_EN (adds CRC_A check, out_crc_ok).
// Ports:
//   clk, rst_n        carrier clock, asynchronous active-low reset
//   in_soc/in_eoc     start / end of frame strobes
//   in_error          upstream timing error strobe
//   in_data(_valid)   received bit and its strobe
//   out_soc/out_eoc   frame start / end, 1 tick after the input strobe
//   out_error         parity, framing or forwarded error (max one per frame)
//   out_data          assembled byte, bit0 first received
//   out_data_bits     valid bits in out_data, 0 means 8
//   out_data_valid    out_data/out_data_bits strobe
//   out_crc_ok        (FRAME_DECODE_CRC_EN) residue ok and whole bytes, at eoc
// All outputs are registered; latency is exactly one clock.
// ----------------------------------------------------------------------------
module frame_decode
  import frame_decode_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_soc,
  input  logic       in_eoc,
  input  logic       in_error,
  input  logic       in_data,
  input  logic       in_data_valid,
  output logic       out_soc,
  output logic       out_eoc,
  output logic       out_error,
  output logic [7:0] out_data,
  output logic [2:0] out_data_bits,
  output logic       out_data_valid
`ifdef FRAME_DECODE_CRC_EN
  ,
  output logic       out_crc_ok
`endif
);

  FrameDecodeState state_q;
  logic [7:0]      shift_q;
  logic [2:0]      cnt_q;
  logic            soc_q;
  logic            eoc_q;
  logic            err_q;
  logic            dv_q;
  logic [7:0]      data_q;
  logic [2:0]      bits_q;

`ifdef FRAME_DECODE_CRC_EN
  logic [15:0] crc_w;
  logic        crc_ok_q;

  crc_a_bitwise u_crc (
    .clk    (clk),
    .rst_n  (rst_n),
    .init   (in_soc),
    .en     ((state_q == DATA) && in_data_valid && !in_soc),
    .bit_in (in_data),
    .crc    (crc_w)
  );

  assign out_crc_ok = crc_ok_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      soc_q   <= 1'b0;
      eoc_q   <= 1'b0;
      err_q   <= 1'b0;
      dv_q    <= 1'b0;
      data_q  <= '0;
      bits_q  <= '0;
`ifdef FRAME_DECODE_CRC_EN
      crc_ok_q <= 1'b0;
`endif
    end else begin
      soc_q <= 1'b0;
      eoc_q <= 1'b0;
      err_q <= 1'b0;
      dv_q  <= 1'b0;
`ifdef FRAME_DECODE_CRC_EN
      crc_ok_q <= 1'b0;
`endif
      // A start of frame restarts assembly from any state; an open frame is
      // abandoned without an end strobe.
      if (in_soc) begin
        soc_q   <= 1'b1;
        shift_q <= '0;
        cnt_q   <= '0;
        state_q <= DATA;
      end else begin
        case (state_q)
          IDLE: ;
          DATA: begin
            if (in_error) begin
              err_q   <= 1'b1;
              state_q <= ERROR;
            end else if (in_eoc) begin
              eoc_q <= 1'b1;
              if (cnt_q != 3'd0) begin
                // Short / partial final byte; upper bits are already zero.
                dv_q   <= 1'b1;
                data_q <= shift_q;
                bits_q <= cnt_q;
              end
`ifdef FRAME_DECODE_CRC_EN
              crc_ok_q <= (cnt_q == 3'd0) && (crc_w == CRC_A_RESIDUE);
`endif
              state_q <= IDLE;
            end else if (in_data_valid) begin
              shift_q[cnt_q] <= in_data;
              cnt_q          <= cnt_q + 3'd1;  // wraps to 0 after bit 7
              if (cnt_q == 3'd7) begin
                state_q <= PARITY;
              end
            end
          end
          PARITY: begin
            if (in_error) begin
              err_q   <= 1'b1;
              state_q <= ERROR;
            end else if (in_eoc) begin
              err_q   <= 1'b1;
              eoc_q   <= 1'b1;
              state_q <= IDLE;
            end else if (in_data_valid) begin
              if (^{shift_q, in_data}) begin
                dv_q    <= 1'b1;
                data_q  <= shift_q;
                bits_q  <= 3'd0;
                shift_q <= '0;
                cnt_q   <= '0;
                state_q <= DATA;
              end else begin
                err_q   <= 1'b1;
                state_q <= ERROR;
              end
            end
          end
          ERROR: begin
            if (in_eoc) begin
              eoc_q   <= 1'b1;
              state_q <= IDLE;
            end
          end
        endcase
      end
    end
  end

  assign out_soc        = soc_q;
  assign out_eoc        = eoc_q;
  assign out_error      = err_q;
  assign out_data_valid = dv_q;
  assign out_data       = data_q;
  assign out_data_bits  = bits_q;

endmodule

// File: tb/tb_frame_decode.sv
// ----------------------------------------------------------------------------
// tb_frame_decode
// Scoreboard bench for frame_decode. A frame-level reference model (bit list
// per frame, byte list for CRC_A) predicts every output event; a monitor pops
// and compares whenever the DUT raises any output strobe.
// ----------------------------------------------------------------------------
module tb_frame_decode;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_soc = 1'b0, in_eoc = 1'b0, in_error = 1'b0;
  logic       in_data = 1'b0, in_data_valid = 1'b0;
  logic       out_soc, out_eoc, out_error, out_data_valid;
  logic [7:0] out_data;
  logic [2:0] out_data_bits;
  logic       crc_ok_w;

  always #5 clk = ~clk;

  frame_decode dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_soc         (in_soc),
    .in_eoc         (in_eoc),
    .in_error       (in_error),
    .in_data        (in_data),
    .in_data_valid  (in_data_valid),
    .out_soc        (out_soc),
    .out_eoc        (out_eoc),
    .out_error      (out_error),
    .out_data       (out_data),
    .out_data_bits  (out_data_bits),
    .out_data_valid (out_data_valid)
`ifdef FRAME_DECODE_CRC_EN
    ,
    .out_crc_ok     (crc_ok_w)
`endif
  );

`ifndef FRAME_DECODE_CRC_EN
  assign crc_ok_w = 1'b0;
`endif

  typedef struct packed {
    logic       soc;
    logic       eoc;
    logic       err;
    logic       dv;
    logic [7:0] data;
    logic [2:0] bits;
    logic       crc;
  } ev_t;

  ev_t exp_q[$];
  int  n_cmp = 0;
  int  n_bad = 0;

  // ---------------- reference model ----------------
  bit         m_in_frame = 0;
  bit         m_err = 0;
  bit         m_bits[$];
  logic [7:0] m_bytes[$];
  logic [7:0] m_data = 8'h00;
  logic [2:0] m_nbits = 3'd0;

  // Byte-wise CRC_A as in the ISO/IEC 14443-3 reference code.
  function automatic logic [15:0] crc_a(input logic [7:0] b[$]);
    logic [15:0] c;
    logic [7:0]  ch;
    c = 16'h6363;
    foreach (b[i]) begin
      ch = b[i] ^ c[7:0];
      ch = ch ^ (ch << 4);
      c  = (c >> 8) ^ ({8'h00, ch} << 8) ^ ({8'h00, ch} << 3) ^ ({8'h00, ch} >> 4);
    end
    return c;
  endfunction

  task automatic model(input int kind, input bit d);
    ev_t e;
    int  ones;
    logic [7:0] v;
    e = '0;
    case (kind)
      1: begin
        m_in_frame = 1; m_err = 0; m_bits.delete(); m_bytes.delete();
        e.soc = 1'b1;
      end
      2: if (m_in_frame) begin
        m_in_frame = 0;
        e.eoc = 1'b1;
        if (!m_err) begin
          if (m_bits.size() == 8) e.err = 1'b1;
          else if (m_bits.size() > 0) begin
            v = '0;
            foreach (m_bits[i]) v[i] = m_bits[i];
            m_data = v; m_nbits = 3'(m_bits.size()); e.dv = 1'b1;
          end else begin
`ifdef FRAME_DECODE_CRC_EN
            e.crc = (crc_a(m_bytes) == 16'h0000);
`endif
          end
        end
      end
      3: if (m_in_frame && !m_err) begin
        m_err = 1; e.err = 1'b1;
      end
      4: if (m_in_frame && !m_err) begin
        m_bits.push_back(d);
        if (m_bits.size() == 9) begin
          ones = 0;
          foreach (m_bits[i]) ones += int'(m_bits[i]);
          if (ones % 2 == 1) begin
            v = '0;
            for (int i = 0; i < 8; i++) v[i] = m_bits[i];
            m_data = v; m_nbits = 3'd0; e.dv = 1'b1;
            m_bytes.push_back(v);
            m_bits.delete();
          end else begin
            m_err = 1; e.err = 1'b1;
          end
        end
      end
      default: ;
    endcase
    if (e.soc || e.eoc || e.err || e.dv) begin
      e.data = m_data;
      e.bits = m_nbits;
      exp_q.push_back(e);
    end
  endtask

  // ---------------- stimulus helpers ----------------
  // kind: 0 idle, 1 soc, 2 eoc, 3 error, 4 data bit
  task automatic send(input int kind, input bit d);
    @(negedge clk);
    in_soc        = (kind == 1);
    in_eoc        = (kind == 2);
    in_error      = (kind == 3);
    in_data_valid = (kind == 4);
    in_data       = (kind == 4) ? d : 1'($urandom_range(0, 1));
    model(kind, d);
  endtask

  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) send(4, b[i]);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit par_ok);
    send_bits(b, 8);
    send(4, par_ok ? ~(^b) : (^b));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) send(0, 1'b0);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    ev_t act, exp_e;
    if (rst_n && (out_soc || out_eoc || out_error || out_data_valid)) begin
      act = '{out_soc, out_eoc, out_error, out_data_valid, out_data, out_data_bits, crc_ok_w};
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL out_event: unexpected output soc=%0b eoc=%0b err=%0b dv=%0b data=%h bits=%0d crc=%0b, required none",
                 act.soc, act.eoc, act.err, act.dv, act.data, act.bits, act.crc);
      end else begin
        exp_e = exp_q.pop_front();
        if (act !== exp_e) begin
          n_bad++;
          $display("FAIL out_event: got soc=%0b eoc=%0b err=%0b dv=%0b data=%h bits=%0d crc=%0b, required soc=%0b eoc=%0b err=%0b dv=%0b data=%h bits=%0d crc=%0b",
                   act.soc, act.eoc, act.err, act.dv, act.data, act.bits, act.crc,
                   exp_e.soc, exp_e.eoc, exp_e.err, exp_e.dv, exp_e.data, exp_e.bits, exp_e.crc);
        end
      end
    end
  end

  task automatic check_reset_outputs();
    ev_t act;
    act = '{out_soc, out_eoc, out_error, out_data_valid, out_data, out_data_bits, crc_ok_w};
    n_cmp++;
    if (act !== '0) begin
      n_bad++;
      $display("FAIL reset_state: got %h, required %h", act, ev_t'('0));
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [7:0] fb[$];
    logic [15:0] c;
    int nb;
    repeat (3) @(negedge clk);
    check_reset_outputs();
    rst_n = 1'b1;
    idle(2);

    // REQA short frame 0x26, 7 bits
    send(1, 0); send_bits(8'h26, 7); send(2, 0); idle(2);
    // SEL 0x93 with correct parity
    send(1, 0); send_byte(8'h93, 1); send(2, 0); idle(2);
    // SEL with bad parity, then 4 more bits dropped
    send(1, 0); send_byte(8'h93, 0); send_bits(8'h0F, 4); send(2, 0); idle(2);
    // 8 data bits without parity
    send(1, 0); send_bits(8'hA5, 8); send(2, 0); idle(2);
    // upstream error mid-byte, more bits, second error
    send(1, 0); send_bits(8'h55, 3); send(3, 0); send_bits(8'hFF, 5); send(3, 0); send(2, 0); idle(2);
    // stray strobes while idle produce nothing
    send(2, 0); send(4, 1); send(3, 0); idle(1);
    // soc mid-frame abandons the frame silently
    send(1, 0); send_bits(8'h3C, 5); send(1, 0); send_byte(8'h01, 1); send(2, 0); idle(2);
    // whole byte followed by partial byte
    send(1, 0); send_byte(8'hFE, 1); send_bits(8'h05, 3); send(2, 0); idle(2);
    // HLTA with valid CRC, then with one data bit flipped
    send(1, 0); send_byte(8'h50, 1); send_byte(8'h00, 1); send_byte(8'h57, 1); send_byte(8'hCD, 1);
    send(2, 0); idle(2);
    send(1, 0); send_byte(8'h51, 1); send_byte(8'h00, 1); send_byte(8'h57, 1); send_byte(8'hCD, 1);
    send(2, 0); idle(2);

    // reset mid-frame: outputs clear at once, no eoc afterwards
    send(1, 0); send_byte(8'hC3, 1); send_bits(8'h07, 3); idle(2);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_outputs();
    m_in_frame = 0; m_err = 0; m_bits.delete(); m_bytes.delete();
    m_data = 8'h00; m_nbits = 3'd0;
    @(negedge clk);
    rst_n = 1'b1;
    send(2, 0); idle(2);

    // randomized frames
    for (int f = 0; f < 150; f++) begin
      send(1, 0);
      fb.delete();
      nb = $urandom_range(0, 4);
      for (int i = 0; i < nb; i++) fb.push_back(8'($urandom));
      if ($urandom_range(0, 1) == 1) begin
        c = crc_a(fb);
        fb.push_back(c[7:0]);
        fb.push_back(c[15:8]);
      end
      foreach (fb[i]) begin
        if ($urandom_range(0, 39) == 0) send(3, 0);
        send_byte(fb[i], $urandom_range(0, 19) != 0);
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      end
      case ($urandom_range(0, 9))
        0, 1, 2: send_bits(8'($urandom), $urandom_range(1, 7));
        3:       send_bits(8'($urandom), 8);
        default: ;
      endcase
      if ($urandom_range(0, 19) != 0) send(2, 0);
      idle($urandom_range(0, 2));
      if ($urandom_range(0, 9) == 0) send($urandom_range(2, 4), 1'($urandom));
    end

    idle(4);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expected events never seen, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/frame_decode.md
Name: frame_decode

Overview:
- Downstream neighbour of the PCD->PICC bit-level sequence decoder.
- Consumes its per-bit stream (soc/eoc/error/data strobes, one bit per strobe, LSB first) and assembles ISO/IEC 14443-3 frames into bytes.
- Checks and strips the odd parity bit that follows every 8 data bits.
- Reports short and partial final bytes with a valid-bit count; feeds the ISO 14443-3/4 protocol layers.

Parameters:
- none (bit order, parity sense and byte width are fixed by ISO/IEC 14443-3)

Ports:
- clk  input  1  13.56 MHz recovered carrier clock; stops during pauses
- rst_n  input  1  asynchronous active-low reset (synchronised deassert)
- in_soc  input  1  start of frame strobe, 1 tick
- in_eoc  input  1  end of frame strobe, 1 tick
- in_error  input  1  upstream timing error strobe, 1 tick
- in_data  input  1  received bit, qualified by in_data_valid
- in_data_valid  input  1  bit strobe, 1 tick
- out_soc  output  1  frame start, 1 tick
- out_eoc  output  1  frame end, 1 tick
- out_error  output  1  parity, framing or forwarded upstream error, 1 tick
- out_data  output  8  assembled byte, bit0 = first received
- out_data_bits  output  3  valid bits in out_data; 0 means all 8
- out_data_valid  output  1  out_data/out_data_bits valid, 1 tick
- out_crc_ok  output  1  only with FRAME_DECODE_CRC_EN; valid when out_eoc=1

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low (clk, rst_n).
- Reset values:
  - all strobes = 0
  - out_data = 8'h00
  - out_data_bits = 0
  - out_crc_ok = 0
  - state = IDLE
  - bit counter = 0
- Timing:
  - All outputs registered; latency from the causing input strobe is exactly 1 tick.
  - Input strobes are mutually exclusive and no more than one per tick; the upstream decoder guarantees this.
- State machine: IDLE, DATA, PARITY, ERROR.
- IDLE:
  - in_soc -> out_soc, clear shift register, bit counter = 0, go to DATA.
  - All other inputs are ignored.
- DATA:
  - Each in_data_valid shifts in_data into bit position counter.
  - Counter 0..7; on the 8th bit go to PARITY.
- PARITY:
  - The next in_data_valid is the parity bit.
  - If XOR of 8 data bits and the parity bit = 1 (odd parity OK): out_data_valid=1, out_data_bits=0, counter=0, go to DATA.
  - Otherwise: out_error=1, no data, go to ERROR.
- EOC handling:
  - In DATA with counter 1..7: out_data_valid=1, out_data_bits=counter, out_data = partial byte (upper bits 0), and out_eoc=1, all in the same tick. Go to IDLE.
  - In DATA with counter 0: out_eoc only. Go to IDLE.
  - In PARITY (8 bits, parity missing): out_error=1 and out_eoc=1, no data. Go to IDLE.
  - In ERROR: out_eoc only. Go to IDLE.
- in_error in DATA/PARITY: out_error=1, go to ERROR.
- in_error in ERROR: ignored; at most one out_error per frame.
- ERROR drops all bits until in_eoc or in_soc.
- in_soc outside IDLE: the current frame is abandoned without out_eoc; out_soc is issued and the frame restarts in DATA.
- Reset mid-frame: immediate return to reset values; no eoc is generated.

Optional Feature:
- Macro: FRAME_DECODE_CRC_EN.
- When defined:
  - A CRC_A engine runs bitwise over every data bit accepted in DATA (not parity bits).
  - CRC_A: poly 0x1021 reflected (0x8408), init 0x6363, LSB first.
  - Reset to init on in_soc.
  - out_crc_ok is registered with out_eoc: 1 iff the final residue == 16'h0000 and the frame contained only whole bytes.
- When not defined: the out_crc_ok port and CRC logic are absent.

Decomposition:
- Shared ISO14443A package:
  - FrameDecodeState enum (IDLE, DATA, PARITY, ERROR)
  - CRC_A_INIT = 16'h6363
  - CRC_A_POLY_REFLECTED = 16'h8408
  - CRC_A_RESIDUE = 16'h0000
- One natural sub-module: crc_a_bitwise (clk, rst_n, init, en, bit_in, crc). Instantiated only under FRAME_DECODE_CRC_EN; reusable by the TX path.

Test Plan:
- REQA short frame: soc, bits 0,1,1,0,0,1,0 (0x26), eoc -> out_soc; one out_data_valid with out_data=8'h26, out_data_bits=7, together with out_eoc; no out_error.
- SEL byte 0x93 + parity 1 + eoc -> out_data=8'h93, out_data_bits=0 one tick after the parity bit; out_eoc next; no error.
- Same stimulus with parity 0, then 4 further bits and eoc -> single out_error after the parity bit; no out_data_valid; out_eoc.
- 8 data bits then eoc (no parity) -> out_error and out_eoc in the same tick; no data.
- in_error mid-byte, further bits, second in_error, eoc -> exactly one out_error, no data, out_eoc.
- (CRC_EN) HLTA 50 00 57 CD with correct parities -> four bytes then out_eoc with out_crc_ok=1; flip one data bit with parity fixed -> out_crc_ok=0.
